cntry_car_detector: RTL and testbench

- Sensor-side front end for the country-road approach of the highway/country traffic light controller.
- Conditions two raw inductive-loop inputs: an entry loop upstream and an exit loop at the stop line.
- Tracks how many vehicles are queued and generates the CAR_ON_CNTRY_ROAD request consumed by the signal controller.
- Observes CNTRY_SIG to decide when the request is served and to flag red-light violations.

---
 rtl/cntry_car_detector_pkg.sv | 9 +
 rtl/cntry_car_detector_loop_debounce.sv | 34 +++
 rtl/cntry_car_detector.sv | 63 ++++++
 tb/tb_cntry_car_detector.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cntry_car_detector_pkg.sv
// cntry_car_detector_pkg: lamp encodings, boolean constants and FSM states for the country-road detector
package cntry_car_detector_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVE = 2'd2} state_t;
endpackage

// File: rtl/cntry_car_detector_loop_debounce.sv
// loop_debounce: 2-flop synchronizer, debounce filter and rising-edge pulse for one inductive loop
module loop_debounce
  import cntry_car_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES - 1);
  logic s1, s2;
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= FALSE;
      s2 <= FALSE;
      level <= FALSE;
      rise <= FALSE;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      rise <= FALSE;
      if (s2 == level) cnt <= '0;
      else if (cnt == LAST) begin
        level <= s2;
        rise <= s2;
        cnt <= '0;
      end else cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/cntry_car_detector.sv
// cntry_car_detector: conditions the country-road loops, tracks the queue and raises the road request
module cntry_car_detector
  import cntry_car_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_W = 4
) (
  input  logic               CLOCK,
  input  logic               CLEAR,
  input  logic               ENTRY_LOOP,
  input  logic               EXIT_LOOP,
  input  logic [1:0]         CNTRY_SIG,
  output logic               CAR_ON_CNTRY_ROAD,
  output logic [COUNT_W-1:0] QUEUE_COUNT,
  output logic               QUEUE_FULL,
  output logic               ERR_RED_RUN,
  output logic               ERR_PHANTOM,
  output logic               ERR_SIG
);
  logic entry_level, exit_level, arrival, departure, red, empty;
  state_t state, state_next;
  loop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
    .clk(CLOCK), .rst_n(CLEAR), .raw(ENTRY_LOOP), .level(entry_level), .rise(arrival)
  );
  loop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
    .clk(CLOCK), .rst_n(CLEAR), .raw(EXIT_LOOP), .level(exit_level), .rise(departure)
  );
  // the illegal lamp code is handled as RED
  assign red = (CNTRY_SIG == RED) || (CNTRY_SIG == 2'd3);
  assign empty = QUEUE_COUNT == '0;
  assign QUEUE_FULL = &QUEUE_COUNT;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = empty ? IDLE : REQ;
      REQ:     state_next = empty ? IDLE : (CNTRY_SIG == GREEN) ? SERVE : REQ;
      SERVE:   state_next = empty ? IDLE : red ? REQ : SERVE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK or negedge CLEAR)
    if (!CLEAR) begin
      state <= IDLE;
      CAR_ON_CNTRY_ROAD <= FALSE;
      QUEUE_COUNT <= '0;
      ERR_RED_RUN <= FALSE;
      ERR_PHANTOM <= FALSE;
      ERR_SIG <= FALSE;
    end else begin
      state <= state_next;
      CAR_ON_CNTRY_ROAD <= state_next != IDLE;
      if (arrival && !departure) begin
        if (QUEUE_FULL) ERR_PHANTOM <= TRUE;
        else QUEUE_COUNT <= QUEUE_COUNT + 1'b1;
      end
      if (departure && !arrival) begin
        if (empty) ERR_PHANTOM <= TRUE;
        else QUEUE_COUNT <= QUEUE_COUNT - 1'b1;
      end
      if (departure && red) ERR_RED_RUN <= TRUE;
      if (CNTRY_SIG == 2'd3) ERR_SIG <= TRUE;
    end
endmodule

// File: tb/tb_cntry_car_detector.sv
// tb_cntry_car_detector: directed-vector bench for the country-road car detector
module tb_cntry_car_detector;
  logic CLOCK = 1'b0, CLEAR = 1'b0, ENTRY_LOOP = 1'b0, EXIT_LOOP = 1'b0;
  logic [1:0] CNTRY_SIG = 2'd0;
  logic CAR_ON_CNTRY_ROAD, QUEUE_FULL, ERR_RED_RUN, ERR_PHANTOM, ERR_SIG;
  logic [3:0] QUEUE_COUNT;
  int total = 0, bad = 0;

  cntry_car_detector #(.DEBOUNCE_CYCLES(4), .COUNT_W(4)) dut (
    .CLOCK(CLOCK), .CLEAR(CLEAR), .ENTRY_LOOP(ENTRY_LOOP), .EXIT_LOOP(EXIT_LOOP),
    .CNTRY_SIG(CNTRY_SIG), .CAR_ON_CNTRY_ROAD(CAR_ON_CNTRY_ROAD), .QUEUE_COUNT(QUEUE_COUNT),
    .QUEUE_FULL(QUEUE_FULL), .ERR_RED_RUN(ERR_RED_RUN), .ERR_PHANTOM(ERR_PHANTOM), .ERR_SIG(ERR_SIG)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic car_in();
    ENTRY_LOOP = 1'b1;
    repeat (10) tick();
    ENTRY_LOOP = 1'b0;
    repeat (8) tick();
  endtask

  task automatic car_out();
    EXIT_LOOP = 1'b1;
    repeat (10) tick();
    EXIT_LOOP = 1'b0;
    repeat (8) tick();
  endtask

  task automatic do_reset();
    CLEAR = 1'b0;
    repeat (3) tick();
    CLEAR = 1'b1;
    tick();
  endtask

  initial begin
    // reset then idle
    repeat (3) tick();
    chk("rst_car", CAR_ON_CNTRY_ROAD, 0);
    chk("rst_count", QUEUE_COUNT, 0);
    chk("rst_full", QUEUE_FULL, 0);
    chk("rst_redrun", ERR_RED_RUN, 0);
    chk("rst_phantom", ERR_PHANTOM, 0);
    chk("rst_sig", ERR_SIG, 0);
    CLEAR = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_count", QUEUE_COUNT, 0);
    end
    // arrival latency: entry driven just after edge k
    ENTRY_LOOP = 1'b1;
    repeat (6) tick();
    chk("lat_count_k6", QUEUE_COUNT, 0);
    tick();
    chk("lat_count_k7", QUEUE_COUNT, 1);
    chk("lat_car_k7", CAR_ON_CNTRY_ROAD, 0);
    tick();
    chk("lat_car_k8", CAR_ON_CNTRY_ROAD, 1);
    repeat (2) tick();
    ENTRY_LOOP = 1'b0;
    repeat (8) tick();
    chk("lat_count_hold", QUEUE_COUNT, 1);
    ENTRY_LOOP = 1'b1;
    repeat (3) tick();
    ENTRY_LOOP = 1'b0;
    repeat (10) tick();
    chk("glitch_count", QUEUE_COUNT, 1);
    // serve cycle
    car_in();
    car_in();
    chk("serve_count3", QUEUE_COUNT, 3);
    CNTRY_SIG = 2'd2;
    repeat (3) tick();
    car_out();
    car_out();
    chk("serve_count1", QUEUE_COUNT, 1);
    chk("serve_car", CAR_ON_CNTRY_ROAD, 1);
    EXIT_LOOP = 1'b1;
    repeat (6) tick();
    chk("serve_pre0", QUEUE_COUNT, 1);
    tick();
    chk("serve_count0", QUEUE_COUNT, 0);
    chk("serve_car_hold", CAR_ON_CNTRY_ROAD, 1);
    tick();
    chk("serve_car_drop", CAR_ON_CNTRY_ROAD, 0);
    repeat (2) tick();
    EXIT_LOOP = 1'b0;
    repeat (8) tick();
    chk("serve_redrun", ERR_RED_RUN, 0);
    chk("serve_phantom", ERR_PHANTOM, 0);
    chk("serve_sig", ERR_SIG, 0);
    // partial serve then red-light run
    car_in();
    car_in();
    car_out();
    chk("part_count1", QUEUE_COUNT, 1);
    CNTRY_SIG = 2'd0;
    repeat (3) tick();
    chk("part_car_req", CAR_ON_CNTRY_ROAD, 1);
    chk("part_count_hold", QUEUE_COUNT, 1);
    chk("part_redrun0", ERR_RED_RUN, 0);
    car_out();
    chk("run_redrun", ERR_RED_RUN, 1);
    chk("run_count", QUEUE_COUNT, 0);
    chk("run_car", CAR_ON_CNTRY_ROAD, 0);
    chk("run_phantom", ERR_PHANTOM, 0);
    // saturation
    do_reset();
    chk("clr_redrun", ERR_RED_RUN, 0);
    CNTRY_SIG = 2'd2;
    for (int i = 0; i < 15; i++) car_in();
    chk("sat_count15", QUEUE_COUNT, 15);
    chk("sat_full", QUEUE_FULL, 1);
    chk("sat_phantom0", ERR_PHANTOM, 0);
    car_in();
    chk("sat_count_hold", QUEUE_COUNT, 15);
    chk("sat_phantom", ERR_PHANTOM, 1);
    // departure from empty queue
    do_reset();
    chk("clr_phantom", ERR_PHANTOM, 0);
    chk("clr_full", QUEUE_FULL, 0);
    car_out();
    chk("empty_phantom", ERR_PHANTOM, 1);
    chk("empty_count", QUEUE_COUNT, 0);
    // aligned arrival and departure
    do_reset();
    car_in();
    car_in();
    ENTRY_LOOP = 1'b1;
    EXIT_LOOP = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("align_count", QUEUE_COUNT, 2);
    end
    ENTRY_LOOP = 1'b0;
    EXIT_LOOP = 1'b0;
    repeat (8) tick();
    chk("align_phantom", ERR_PHANTOM, 0);
    // asynchronous reset mid-SERVE with five cars queued
    for (int i = 0; i < 3; i++) car_in();
    chk("mid_count5", QUEUE_COUNT, 5);
    chk("mid_car", CAR_ON_CNTRY_ROAD, 1);
    CNTRY_SIG = 2'd0;
    car_out();
    chk("mid_redrun", ERR_RED_RUN, 1);
    CNTRY_SIG = 2'd2;
    car_in();
    repeat (3) tick();
    #1 CLEAR = 1'b0;
    #1;
    chk("async_count", QUEUE_COUNT, 0);
    chk("async_car", CAR_ON_CNTRY_ROAD, 0);
    chk("async_redrun", ERR_RED_RUN, 0);
    tick();
    CLEAR = 1'b1;
    tick();
    // illegal lamp code acts as RED
    car_in();
    repeat (3) tick();
    chk("ill_sig0", ERR_SIG, 0);
    CNTRY_SIG = 2'd3;
    repeat (3) tick();
    chk("ill_sig", ERR_SIG, 1);
    chk("ill_car_req", CAR_ON_CNTRY_ROAD, 1);
    car_out();
    chk("ill_redrun", ERR_RED_RUN, 1);
    chk("ill_count", QUEUE_COUNT, 0);
    chk("ill_car_drop", CAR_ON_CNTRY_ROAD, 0);
    CNTRY_SIG = 2'd0;
    repeat (3) tick();
    chk("ill_sticky", ERR_SIG, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
